// File: rtl/reg_file_nbit.sv
// Parametrised WIDTH x DEPTH register file: one byte-masked write port, two combinational
// read ports, optional hardwired-zero register 0 and optional write-to-read bypass.
module reg_file_nbit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [WIDTH/8-1:0]  wr_be,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [WIDTH-1:0]    rd_data1,
    output logic [WIDTH-1:0]    rd_data2
);

    localparam int unsigned NBYTES = WIDTH / 8;

    if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
        $error("reg_file_nbit: WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("reg_file_nbit: DEPTH must be a power of two and at least 2");
    end
    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
        $error("reg_file_nbit: ADDR_W must equal log2(DEPTH)");
    end
    if (ZERO_REG > 1 || BYPASS > 1) begin : g_bad_flags
        $error("reg_file_nbit: ZERO_REG and BYPASS must be 0 or 1");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] w_merged;
    logic             w_wr_en;
    logic             w_byp_en;

    // Write data merged with the stored bytes it does not cover; feeds both storage and bypass.
    for (genvar b = 0; b < NBYTES; b++) begin : g_merge
        assign w_merged[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : r_mem[wr_addr][8*b +: 8];
    end

    assign w_wr_en  = we && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_byp_en = (BYPASS != 0) && we && !reset;

    for (genvar g = 0; g < DEPTH; g++) begin : g_regs
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mem[g] <= '0;
            end else if (w_wr_en && (wr_addr == ADDR_W'(g))) begin
                r_mem[g] <= w_merged;
            end
        end
    end

    always_comb begin
        rd_data1 = r_mem[rd_addr1];
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end else if (w_byp_en && (rd_addr1 == wr_addr)) begin
            rd_data1 = w_merged;
        end
    end

    always_comb begin
        rd_data2 = r_mem[rd_addr2];
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end else if (w_byp_en && (rd_addr2 == wr_addr)) begin
            rd_data2 = w_merged;
        end
    end

endmodule
